// File: rtl/mem_io_demux.sv
// Routes one CPU load/store at a time to either RAM or the IO window and returns a one-cycle ack.
// Define DEMUX_TIMEOUT_EN to abort stalled target accesses after TIMEOUT wait cycles with err=1.
module mem_io_demux #(
   parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
   parameter logic [31:0] IO_MASK = 32'hFFFF_FC00,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic        ram_ack,
   input  logic [31:0] ram_rdata,
   output logic        io_req,
   output logic        io_we,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   input  logic        io_ack,
   input  logic [31:0] io_rdata
);

   typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic        we_reg, we_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        err_reg, err_next;

   logic        waiting;
   logic        sel_ack;
   logic [31:0] sel_rdata;
   logic        expire;

   assign waiting   = (state_reg == RAM_WAIT) || (state_reg == IO_WAIT);
   // Only the selected target's handshake is looked at; the other one is ignored.
   assign sel_ack   = (state_reg == IO_WAIT) ? io_ack   : ram_ack;
   assign sel_rdata = (state_reg == IO_WAIT) ? io_rdata : ram_rdata;

`ifdef DEMUX_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [7:0] cnt_reg;

   // Counter holds 0 in IDLE, so it starts from 0 on every WAIT entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_reg <= 8'd0;
      else if (state_reg == IDLE)
         cnt_reg <= 8'd0;
      else if (waiting && !sel_ack)
         cnt_reg <= cnt_reg + 8'd1;
   end

   assign expire = waiting && ((cnt_reg + 8'd1) == TIMEOUT_CNT);
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         we_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               we_next    = we;
               addr_next  = addr;
               wdata_next = wdata;
               state_next = ((addr & IO_MASK) == IO_BASE) ? IO_WAIT : RAM_WAIT;
            end
         end
         RAM_WAIT, IO_WAIT: begin
            // An ack in the expiry cycle still wins over the timeout.
            if (sel_ack) begin
               rdata_next = we_reg ? 32'd0 : sel_rdata;
               err_next   = 1'b0;
               state_next = RESP;
            end else if (expire) begin
               rdata_next = 32'd0;
               err_next   = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ack       = (state_reg == RESP);
   assign busy      = (state_reg != IDLE);
   assign rdata     = rdata_reg;
   assign err       = err_reg;

   assign ram_req   = (state_reg == RAM_WAIT);
   assign ram_we    = we_reg;
   assign ram_addr  = addr_reg;
   assign ram_wdata = wdata_reg;

   assign io_req    = (state_reg == IO_WAIT);
   assign io_we     = we_reg;
   assign io_addr   = addr_reg;
   assign io_wdata  = wdata_reg;

endmodule

// File: tb/tb_mem_io_demux.sv
// Self-checking bench for mem_io_demux: directed scenarios plus randomized transactions
// checked against a transaction-level model of routing, latency and response data.
module tb_mem_io_demux;

   localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
   localparam logic [31:0] IO_MASK = 32'hFFFF_FC00;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        ack, err, busy;
   logic [31:0] rdata;
   logic        ram_req, ram_we, ram_ack = 1'b0;
   logic [31:0] ram_addr, ram_wdata, ram_rdata = 32'd0;
   logic        io_req, io_we, io_ack = 1'b0;
   logic [31:0] io_addr, io_wdata, io_rdata = 32'd0;

   int checks = 0;
   int errors = 0;

   // Model of the response registers, which hold between transactions.
   logic [31:0] m_rdata = 32'd0;
   logic        m_err = 1'b0;

   mem_io_demux dut (
      .clock(clock), .reset_n(reset_n),
      .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .err(err), .busy(busy),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_ack(io_ack), .io_rdata(io_rdata)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic bit in_io(input logic [31:0] a);
      return (a & IO_MASK) == IO_BASE;
   endfunction

   // {busy, ack, ram_req, io_req}
   function automatic logic [3:0] flags();
      return {busy, ack, ram_req, io_req};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      checks++;
      if ({flags(), err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b need 00000", {flags(), err});
      end
      checks++;
      if ({rdata, ram_addr, ram_wdata, ram_we} !== 97'd0) begin
         errors++; $display("FAIL reset_regs: got rdata=%h addr=%h wdata=%h we=%b need all 0",
                            rdata, ram_addr, ram_wdata, ram_we);
      end
      step();
      step();
      // Release off-edge; the very next rising edge must accept a request.
      reset_n = 1'b1;
      req = 1'b1; we = 1'b0; addr = 32'h0000_0100; wdata = 32'd0;
      step();
      req = 1'b0;
      checks++;
      if (flags() !== 4'b1010) begin
         errors++; $display("FAIL first_req_after_reset: got %b need 1010", flags());
      end
      ram_ack = 1'b1; ram_rdata = 32'h0BAD_F00D;
      step();
      ram_ack = 1'b0;
      m_rdata = 32'h0BAD_F00D; m_err = 1'b0;
      checks++;
      if (rdata !== m_rdata || flags() !== 4'b1100) begin
         errors++; $display("FAIL first_req_resp: got rdata=%h flags=%b need %h 1100", rdata, flags(), m_rdata);
      end
      step();
      $display("txn reset+first_req done");
   endtask

   task automatic test_ram_load();
      req = 1'b1; we = 1'b0; addr = 32'h0000_0010; wdata = 32'h1111_1111;
      step();
      req = 1'b0;
      checks++;
      if (flags() !== 4'b1010 || ram_addr !== 32'h10 || ram_we !== 1'b0) begin
         errors++; $display("FAIL ram_load_wait: got flags=%b addr=%h we=%b need 1010 10 0", flags(), ram_addr, ram_we);
      end
      ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
      step();
      ram_ack = 1'b0;
      m_rdata = 32'hDEAD_BEEF; m_err = 1'b0;
      checks++;
      if (flags() !== 4'b1100 || rdata !== m_rdata || err !== 1'b0) begin
         errors++; $display("FAIL ram_load_resp: got flags=%b rdata=%h err=%b need 1100 %h 0", flags(), rdata, err, m_rdata);
      end
      step();
      checks++;
      if (flags() !== 4'b0000 || rdata !== m_rdata) begin
         errors++; $display("FAIL ram_load_idle: got flags=%b rdata=%h need 0000 %h", flags(), rdata, m_rdata);
      end
      $display("txn ram_load addr=00000010 rdata=%h", rdata);
   endtask

   task automatic test_io_store();
      req = 1'b1; we = 1'b1; addr = 32'hFFFF_FC60; wdata = 32'h0000_00A5;
      step();
      req = 1'b0; wdata = 32'h5A5A_5A5A;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (flags() !== 4'b1001 || io_we !== 1'b1 || io_wdata !== 32'hA5 || io_addr !== 32'hFFFF_FC60) begin
            errors++; $display("FAIL io_store_wait%0d: got flags=%b we=%b wdata=%h addr=%h need 1001 1 a5 fffffc60",
                               k, flags(), io_we, io_wdata, io_addr);
         end
         if (k == 3) begin io_ack = 1'b1; io_rdata = 32'h1234_5678; end
         step();
      end
      io_ack = 1'b0;
      m_rdata = 32'd0; m_err = 1'b0;
      checks++;
      if (flags() !== 4'b1100 || rdata !== 32'd0 || err !== 1'b0) begin
         errors++; $display("FAIL io_store_resp: got flags=%b rdata=%h err=%b need 1100 0 0", flags(), rdata, err);
      end
      step();
      $display("txn io_store addr=fffffc60 wdata=000000a5");
   endtask

   task automatic test_wrong_ack();
      req = 1'b1; we = 1'b0; addr = 32'h0000_2000;
      step();
      req = 1'b0;
      io_ack = 1'b1; io_rdata = 32'hBAD0_BAD0;
      step();
      io_ack = 1'b0;
      checks++;
      if (flags() !== 4'b1010) begin
         errors++; $display("FAIL wrong_ack_ignored: got flags=%b need 1010", flags());
      end
      ram_ack = 1'b1; ram_rdata = 32'hC0DE_0001;
      step();
      ram_ack = 1'b0;
      m_rdata = 32'hC0DE_0001;
      checks++;
      if (flags() !== 4'b1100 || rdata !== m_rdata) begin
         errors++; $display("FAIL wrong_ack_resp: got flags=%b rdata=%h need 1100 %h", flags(), rdata, m_rdata);
      end
      step();
      $display("txn wrong_ack rdata=%h", rdata);
   endtask

   task automatic test_back_to_back();
      req = 1'b1; we = 1'b0; addr = 32'h0000_0400;
      step();
      addr = 32'hFFFF_FC08;   // req stays high; must not disturb the pending RAM access
      checks++;
      if (flags() !== 4'b1010 || ram_addr !== 32'h0000_0400) begin
         errors++; $display("FAIL b2b_first_wait: got flags=%b addr=%h need 1010 00000400", flags(), ram_addr);
      end
      ram_ack = 1'b1; ram_rdata = 32'h0000_0A0A;
      step();
      ram_ack = 1'b0;
      m_rdata = 32'h0000_0A0A;
      checks++;
      if (flags() !== 4'b1100 || rdata !== m_rdata) begin
         errors++; $display("FAIL b2b_first_resp: got flags=%b rdata=%h need 1100 %h", flags(), rdata, m_rdata);
      end
      step();
      checks++;
      if (flags() !== 4'b0000) begin
         errors++; $display("FAIL b2b_not_during_ack: got flags=%b need 0000", flags());
      end
      step();
      req = 1'b0;
      checks++;
      if (flags() !== 4'b1001 || io_addr !== 32'hFFFF_FC08) begin
         errors++; $display("FAIL b2b_second_accept: got flags=%b addr=%h need 1001 fffffc08", flags(), io_addr);
      end
      io_ack = 1'b1; io_rdata = 32'h0000_0B0B;
      step();
      io_ack = 1'b0;
      m_rdata = 32'h0000_0B0B;
      checks++;
      if (flags() !== 4'b1100 || rdata !== m_rdata) begin
         errors++; $display("FAIL b2b_second_resp: got flags=%b rdata=%h need 1100 %h", flags(), rdata, m_rdata);
      end
      step();
      $display("txn back_to_back done");
   endtask

   task automatic test_reset_mid_wait();
      req = 1'b1; we = 1'b0; addr = 32'hFFFF_FC10;
      step();
      req = 1'b0;
      reset_n = 1'b0;
      #2;
      m_rdata = 32'd0; m_err = 1'b0;
      checks++;
      if (flags() !== 4'b0000 || rdata !== 32'd0) begin
         errors++; $display("FAIL reset_mid_async: got flags=%b rdata=%h need 0000 0", flags(), rdata);
      end
      step();
      reset_n = 1'b1;
      io_ack = 1'b1; io_rdata = 32'hFEED_FACE;
      step();
      io_ack = 1'b0;
      checks++;
      if (flags() !== 4'b0000 || rdata !== 32'd0) begin
         errors++; $display("FAIL reset_mid_late_ack: got flags=%b rdata=%h need 0000 0", flags(), rdata);
      end
      step();
      checks++;
      if (flags() !== 4'b0000) begin
         errors++; $display("FAIL reset_mid_idle: got flags=%b need 0000", flags());
      end
      $display("txn reset_mid_wait done");
   endtask

`ifdef DEMUX_TIMEOUT_EN
   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         req = 1'b1; we = 1'b0; addr = 32'hFFFF_FC20;
         step();
         req = 1'b0;
         for (int k = 0; k < 15; k++) begin
            checks++;
            if (flags() !== 4'b1001) begin
               errors++; $display("FAIL timeout_wait%0d_pass%0d: got flags=%b need 1001", k, pass, flags());
            end
            if (pass == 1 && k == 14) begin io_ack = 1'b1; io_rdata = 32'h7777_0015; end
            step();
         end
         io_ack = 1'b0;
         m_rdata = (pass == 1) ? 32'h7777_0015 : 32'd0;
         m_err   = (pass == 0);
         checks++;
         if (flags() !== 4'b1100 || rdata !== m_rdata || err !== m_err) begin
            errors++; $display("FAIL timeout_resp_pass%0d: got flags=%b rdata=%h err=%b need 1100 %h %b",
                               pass, flags(), rdata, err, m_rdata, m_err);
         end
         step();
         $display("txn timeout pass=%0d err=%b", pass, err);
      end
   endtask
`else
   task automatic test_long_wait();
      req = 1'b1; we = 1'b0; addr = 32'hFFFF_FC20;
      step();
      req = 1'b0;
      for (int k = 0; k < 22; k++) begin
         checks++;
         if (flags() !== 4'b1001) begin
            errors++; $display("FAIL long_wait%0d: got flags=%b need 1001", k, flags());
         end
         if (k == 21) begin io_ack = 1'b1; io_rdata = 32'h2222_0022; end
         step();
      end
      io_ack = 1'b0;
      m_rdata = 32'h2222_0022; m_err = 1'b0;
      checks++;
      if (flags() !== 4'b1100 || rdata !== m_rdata || err !== 1'b0) begin
         errors++; $display("FAIL long_wait_resp: got flags=%b rdata=%h err=%b need 1100 %h 0", flags(), rdata, err, m_rdata);
      end
      step();
      $display("txn long_wait done");
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic        t_we, t_io;
         logic [31:0] t_addr, t_wdata, t_rd, junk;
         int          lat, wrong_at, gap;
         t_we    = 1'($urandom_range(0, 1));
         t_addr  = ($urandom_range(0, 1) == 1) ? (IO_BASE | ($urandom() & ~IO_MASK)) : $urandom();
         t_wdata = $urandom();
         t_rd    = $urandom();
         lat     = $urandom_range(0, 6);
         wrong_at = (lat > 0) ? $urandom_range(0, lat - 1) : -1;
         t_io    = in_io(t_addr);
         gap     = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step();
         req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
         step();
         for (int k = 0; k <= lat; k++) begin
            // Random traffic on the CPU side while busy must be ignored.
            junk = $urandom();
            req = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            we = junk[0]; addr = junk; wdata = ~junk;
            checks++;
            if (flags() !== {2'b10, ~t_io, t_io}) begin
               errors++; $display("FAIL rand%0d_wait%0d_flags: got %b need %b", n, k, flags(), {2'b10, ~t_io, t_io});
            end
            checks++;
            if ((t_io ? {io_we, io_addr, io_wdata} : {ram_we, ram_addr, ram_wdata}) !== {t_we, t_addr, t_wdata}) begin
               errors++; $display("FAIL rand%0d_wait%0d_latched: need we=%b addr=%h wdata=%h", n, k, t_we, t_addr, t_wdata);
            end
            if (k == wrong_at) begin
               if (t_io) begin ram_ack = 1'b1; ram_rdata = junk; end
               else begin io_ack = 1'b1; io_rdata = junk; end
            end
            if (k == lat) begin
               if (t_io) begin io_ack = 1'b1; io_rdata = t_rd; end
               else begin ram_ack = 1'b1; ram_rdata = t_rd; end
            end
            step();
            ram_ack = 1'b0; io_ack = 1'b0;
         end
         m_rdata = t_we ? 32'd0 : t_rd;
         m_err = 1'b0;
         checks++;
         if (flags() !== 4'b1100 || rdata !== m_rdata || err !== m_err) begin
            errors++; $display("FAIL rand%0d_resp: got flags=%b rdata=%h err=%b need 1100 %h 0", n, flags(), rdata, err, m_rdata);
         end
         step();
         checks++;
         if (flags() !== 4'b0000 || rdata !== m_rdata) begin
            errors++; $display("FAIL rand%0d_idle: got flags=%b rdata=%h need 0000 %h", n, flags(), rdata, m_rdata);
         end
         $display("txn rand%0d %s %s addr=%h lat=%0d rdata=%h", n, t_io ? "io" : "ram",
                  t_we ? "st" : "ld", t_addr, lat + 2, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_ram_load();
      test_io_store();
      test_wrong_ack();
      test_back_to_back();
      test_reset_mid_wait();
`ifdef DEMUX_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
